// File: rtl/alu_1_pkg.sv
// Shared definitions for the alu_1 exerciser: opcodes, vector bit map, FSM states
// and the golden slice function used both on-chip and by benches.
package alu_1_pkg;

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_OR    = 3'b001;
  localparam logic [2:0] OP_XOR   = 3'b010;
  localparam logic [2:0] OP_NOTA  = 3'b011;
  localparam logic [2:0] OP_ADD   = 3'b100;
  localparam logic [2:0] OP_SUB   = 3'b101;
  localparam logic [2:0] OP_PASSA = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  localparam int VEC_A  = 0;
  localparam int VEC_B  = 1;
  localparam int VEC_CN = 2;
  localparam int VEC_S0 = 3;
  localparam int VEC_S1 = 4;
  localparam int VEC_S2 = 5;

  localparam logic [5:0] LAST_VEC = 6'd63;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Returns {cn_1, y} for a 6-bit slice input vector.
  function automatic logic [1:0] alu_1_golden(input logic [5:0] vec);
    logic       a;
    logic       b;
    logic       cn;
    logic       y;
    logic       c;
    logic [2:0] op;
    a  = vec[VEC_A];
    b  = vec[VEC_B];
    cn = vec[VEC_CN];
    op = {vec[VEC_S2], vec[VEC_S1], vec[VEC_S0]};
    y  = 1'b0;
    c  = 1'b0;
    case (op)
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_NOTA:  y = ~a;
      OP_ADD: begin
        y = a ^ b ^ cn;
        c = (a & b) | (a & cn) | (b & cn);
      end
      OP_SUB: begin
        y = a ^ ~b ^ cn;
        c = (a & ~b) | (a & cn) | (~b & cn);
      end
      OP_PASSA: y = a;
      default:  y = b;
    endcase
    return {c, y};
  endfunction

endpackage

// File: rtl/alu_1_exerciser_model.sv
// Combinational golden reference for the alu_1 slice.
module alu_1_model
  import alu_1_pkg::*;
(
  input  logic [5:0] i_vec,
  output logic       o_y,
  output logic       o_cn_1
);

  logic [1:0] w_res;

  assign w_res  = alu_1_golden(i_vec);
  assign o_y    = w_res[0];
  assign o_cn_1 = w_res[1];

endmodule

// File: rtl/alu_1_exerciser.sv
// Sweeps all 64 vectors into an alu_1 slice, compares each response against the
// golden model and reports pass/fail, error count and the first failing vector.
module alu_1_exerciser
  import alu_1_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [5:0] vec_out,
  input  logic       y_in,
  input  logic       cn_1_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] err_count,
  output logic [5:0] first_fail_vec,
  output logic       first_fail_valid
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_e     r_state;
  logic [5:0] r_vec;
  logic [3:0] r_cnt;
  logic [6:0] r_err;
  logic [5:0] r_ff_vec;
  logic       r_ff_valid;
  logic       r_pass;

  state_e     w_state_next;
  logic [5:0] w_vec_next;
  logic [3:0] w_cnt_next;
  logic [6:0] w_err_next;
  logic [5:0] w_ff_vec_next;
  logic       w_ff_valid_next;
  logic       w_pass_next;
  logic       w_launch;
  logic       w_golden_y;
  logic       w_golden_cn_1;
  logic       w_mismatch;

  alu_1_model u_model (
    .i_vec  (r_vec),
    .o_y    (w_golden_y),
    .o_cn_1 (w_golden_cn_1)
  );

  assign w_mismatch = ({cn_1_in, y_in} != {w_golden_cn_1, w_golden_y});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_vec      <= '0;
      r_cnt      <= '0;
      r_err      <= '0;
      r_ff_vec   <= '0;
      r_ff_valid <= 1'b0;
      r_pass     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_vec      <= w_vec_next;
      r_cnt      <= w_cnt_next;
      r_err      <= w_err_next;
      r_ff_vec   <= w_ff_vec_next;
      r_ff_valid <= w_ff_valid_next;
      r_pass     <= w_pass_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_vec_next      = r_vec;
    w_cnt_next      = r_cnt;
    w_err_next      = r_err;
    w_ff_vec_next   = r_ff_vec;
    w_ff_valid_next = r_ff_valid;
    w_pass_next     = r_pass;
    w_launch        = 1'b0;

    unique case (r_state)
      StIdle: w_launch = start;
      StRun: begin
        if (r_cnt == SETTLE_LAST) begin
          if (w_mismatch) begin
            w_err_next = r_err + 7'd1;
            if (!r_ff_valid) begin
              w_ff_vec_next   = r_vec;
              w_ff_valid_next = 1'b1;
            end
          end
          // Vector 63 is the last sample; no wrap inside a sweep.
          if (r_vec == LAST_VEC) begin
            w_state_next = StDone;
            w_pass_next  = (w_err_next == 7'd0);
          end else begin
            w_vec_next = r_vec + 6'd1;
            w_cnt_next = '0;
          end
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      StDone: w_launch = start;
      default: w_state_next = StIdle;
    endcase

    if (w_launch) begin
      w_state_next    = StRun;
      w_vec_next      = '0;
      w_cnt_next      = '0;
      w_err_next      = '0;
      w_ff_vec_next   = '0;
      w_ff_valid_next = 1'b0;
      w_pass_next     = 1'b0;
    end
  end

  assign vec_out          = r_vec;
  assign busy             = (r_state == StRun);
  assign done             = (r_state == StDone);
  assign pass             = r_pass;
  assign err_count        = r_err;
  assign first_fail_vec   = r_ff_vec;
  assign first_fail_valid = r_ff_valid;

endmodule

// File: tb/tb_alu_1_exerciser.sv
// Self-checking bench: three exercisers (S=2, S=1, S=15) driving a bench-side slice
// with selectable faults, checked against an arithmetic reference model.
module tb_alu_1_exerciser;

  logic       clk;
  logic       rst;
  logic       start    [3];
  logic [5:0] vec      [3];
  logic       y_s      [3];
  logic       cn_s     [3];
  logic       busy     [3];
  logic       done     [3];
  logic       pass     [3];
  logic [6:0] err      [3];
  logic [5:0] ffv      [3];
  logic       ffval    [3];

  logic [5:0] mvec;
  logic       my;
  logic       mcn;

  int         mode;
  logic [63:0] ymask;
  logic [63:0] cmask;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_1_exerciser #(.SETTLE_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start[0]), .vec_out(vec[0]), .y_in(y_s[0]),
    .cn_1_in(cn_s[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(err[0]), .first_fail_vec(ffv[0]), .first_fail_valid(ffval[0])
  );

  alu_1_exerciser #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .vec_out(vec[1]), .y_in(y_s[1]),
    .cn_1_in(cn_s[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(err[1]), .first_fail_vec(ffv[1]), .first_fail_valid(ffval[1])
  );

  alu_1_exerciser #(.SETTLE_CYCLES(15)) u_dut15 (
    .clk(clk), .rst(rst), .start(start[2]), .vec_out(vec[2]), .y_in(y_s[2]),
    .cn_1_in(cn_s[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
    .err_count(err[2]), .first_fail_vec(ffv[2]), .first_fail_valid(ffval[2])
  );

  alu_1_model u_model (
    .i_vec  (mvec),
    .o_y    (my),
    .o_cn_1 (mcn)
  );

  // Reference: ALU rules evaluated with integer arithmetic; returns {cn_1, y}.
  function automatic logic [1:0] ref_golden(input logic [5:0] v);
    int a, b, c, op, s, y, k;
    a  = int'(v[0]);
    b  = int'(v[1]);
    c  = int'(v[2]);
    op = int'(v[5:3]);
    y  = 0;
    k  = 0;
    case (op)
      0: y = a * b;
      1: y = (a + b > 0) ? 1 : 0;
      2: y = (a + b) % 2;
      3: y = 1 - a;
      4: begin s = a + b + c; y = s % 2; k = s / 2; end
      5: begin s = a + (1 - b) + c; y = s % 2; k = s / 2; end
      6: y = a;
      default: y = b;
    endcase
    return {k[0], y[0]};
  endfunction

  function automatic logic [1:0] slice_resp(input logic [5:0] v, input int md,
                                            input logic [63:0] ym, input logic [63:0] cm);
    logic [1:0] g;
    g = ref_golden(v);
    case (md)
      1: g[0] = 1'b0;
      2: g[1] = 1'b0;
      3: g = g ^ {cm[v], ym[v]};
      default: ;
    endcase
    return g;
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      {cn_s[i], y_s[i]} = slice_resp(vec[i], mode, ymask, cmask);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves time at E0 + 1 time unit, E0 being the edge that samples start.
  task automatic launch(input int d);
    @(negedge clk);
    start[d] = 1'b1;
    @(posedge clk);
    #1;
    start[d] = 1'b0;
  endtask

  task automatic expect_sweep(output int e, output int f);
    e = 0;
    f = 0;
    for (int v = 63; v >= 0; v--) begin
      if (slice_resp(6'(v), mode, ymask, cmask) != ref_golden(6'(v))) begin
        e++;
        f = v;
      end
    end
  endtask

  // Runs the remainder of a sweep started by launch() and checks timing and results.
  task automatic body(input int d, input int s, input int ee, input int ef, input int ev,
                      input string tag);
    edges(32 * s);
    check({tag, " mid vec"}, 32'(vec[d]), 32);
    check({tag, " mid busy"}, 32'(busy[d]), 1);
    edges(32 * s - 1);
    check({tag, " last vec"}, 32'(vec[d]), 63);
    check({tag, " pre-done"}, {30'd0, busy[d], done[d]}, 32'b10);
    edges(1);
    check({tag, " done"}, {30'd0, busy[d], done[d]}, 32'b01);
    check({tag, " pass"}, 32'(pass[d]), (ee == 0) ? 1 : 0);
    check({tag, " err"}, 32'(err[d]), ee);
    check({tag, " ffvalid"}, 32'(ffval[d]), ev);
    check({tag, " ffvec"}, 32'(ffv[d]), ef);
  endtask

  task automatic check_reset(input int d, input string tag);
    check({tag, " vec"}, 32'(vec[d]), 0);
    check({tag, " flags"}, {28'd0, busy[d], done[d], pass[d], ffval[d]}, 0);
    check({tag, " err"}, 32'(err[d]), 0);
    check({tag, " ffvec"}, 32'(ffv[d]), 0);
  endtask

  initial begin
    int e, f;
    rst   = 1'b1;
    mode  = 0;
    ymask = '0;
    cmask = '0;
    mvec  = '0;
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    edges(3);
    for (int i = 0; i < 3; i++) check_reset(i, "reset");
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 64; v++) begin
      mvec = 6'(v);
      #1;
      check("model", {30'd0, mcn, my}, 32'(ref_golden(6'(v))));
    end

    mode = 0;
    launch(0);
    check("s2 start vec", 32'(vec[0]), 0);
    body(0, 2, 0, 0, 0, "s2 good");

    mode = 1;
    launch(0);
    body(0, 2, 32, 3, 1, "s2 y0");

    mode = 2;
    launch(0);
    body(0, 2, 8, 35, 1, "s2 cn0");

    mode = 3;
    for (int it = 0; it < 6; it++) begin
      for (int v = 0; v < 64; v++) begin
        ymask[v] = ($urandom_range(7) == 0);
        cmask[v] = ($urandom_range(9) == 0);
      end
      expect_sweep(e, f);
      launch(0);
      body(0, 2, e, f, (e != 0) ? 1 : 0, "s2 rand");
    end

    // Start pulsed mid-RUN must be ignored; start in DONE restarts with results cleared.
    for (int v = 0; v < 64; v++) ymask[v] = ($urandom_range(3) == 0);
    ymask[5] = 1'b1;
    cmask = '0;
    expect_sweep(e, f);
    launch(0);
    edges(50);
    launch(0);
    check("run start busy", 32'(busy[0]), 1);
    check("run start vec", 32'(vec[0]), 25);
    edges(76);
    check("run start pre-done", {30'd0, busy[0], done[0]}, 32'b10);
    edges(1);
    check("run start done", {30'd0, busy[0], done[0]}, 32'b01);
    check("run start err", 32'(err[0]), e);
    check("run start ffvec", 32'(ffv[0]), f);
    mode = 0;
    launch(0);
    check("restart flags", {28'd0, busy[0], done[0], pass[0], ffval[0]}, 32'b1000);
    check("restart err", 32'(err[0]), 0);
    check("restart vec", 32'(vec[0]), 0);
    body(0, 2, 0, 0, 0, "s2 restart");

    // Asynchronous reset mid-sweep on the S=1 exerciser.
    mode = 1;
    e = 0;
    for (int v = 0; v < 20; v++) if (ref_golden(6'(v)) & 2'b01) e++;
    launch(1);
    edges(20);
    check("s1 pre-rst vec", 32'(vec[1]), 20);
    check("s1 pre-rst err", 32'(err[1]), e);
    #2;
    rst = 1'b1;
    #1;
    check_reset(1, "s1 async rst");
    @(negedge clk);
    rst = 1'b0;
    edges(3);
    check("s1 stays idle", {30'd0, busy[1], done[1]}, 0);
    mode = 0;
    launch(1);
    body(1, 1, 0, 0, 0, "s1 after rst");

    launch(2);
    body(2, 15, 0, 0, 0, "s15 good");
    check("s15 vec holds", 32'(vec[2]), 63);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
